// File: rtl/snax_alu_reducer.sv
// Accumulating reducer behind a SNAX ALU PE: sums len_i PE results and hands the total to a consumer.
// Optional build macro SNAX_ALU_REDUCER_SAT_EN selects saturating (instead of wrapping) accumulation.
module snax_alu_reducer #(
    parameter int DataWidth = 64,
    parameter int LenWidth  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [LenWidth-1:0]    len_i,
    input  logic                   issue_i,
    output logic                   acc_ready_o,
    input  logic [2*DataWidth-1:0] c_i,
    input  logic                   c_valid_i,
    output logic                   c_ready_o,
    output logic [2*DataWidth-1:0] sum_o,
    output logic                   sum_valid_o,
    input  logic                   sum_ready_i,
    output logic                   busy_o,
    output logic [LenWidth-1:0]    count_o
);

    localparam int AccWidth = 2 * DataWidth;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic [LenWidth-1:0]   issued_q, issued_d;
    logic [LenWidth-1:0]   count_q, count_d;
    logic [AccWidth-1:0]   acc_q, acc_d;
    logic [AccWidth-1:0]   acc_next;
    logic [LenWidth-1:0]   count_inc;
    logic                  issue_allowed;

`ifdef SNAX_ALU_REDUCER_SAT_EN
    logic [AccWidth:0] acc_sum;

    // Once clamped to all-ones any further addend overflows again, so the clamp holds naturally.
    always_comb begin
        acc_sum  = {1'b0, acc_q} + {1'b0, c_i};
        acc_next = acc_sum[AccWidth] ? {AccWidth{1'b1}} : acc_sum[AccWidth-1:0];
    end
`else
    always_comb begin
        acc_next = acc_q + c_i;
    end
`endif

    assign count_inc     = count_q + LenWidth'(1);
    assign issue_allowed = (state_q == ACCUM) && (issued_q < len_q);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        acc_d    = acc_q;
        issued_d = issued_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d    = len_i;
                    acc_d    = '0;
                    issued_d = '0;
                    count_d  = '0;
                    state_d  = (len_i != '0) ? ACCUM : DRAIN;
                end
            end
            ACCUM: begin
                // Issue is capped at len_q so stray pulses cannot over-count.
                if (issue_i && issue_allowed) begin
                    issued_d = issued_q + LenWidth'(1);
                end
                if (c_valid_i) begin
                    acc_d   = acc_next;
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (sum_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            len_q    <= '0;
            acc_q    <= '0;
            issued_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            issued_q <= issued_d;
            count_q  <= count_d;
        end
    end

    assign acc_ready_o = issue_allowed;
    assign c_ready_o   = (state_q == ACCUM);
    assign sum_valid_o = (state_q == DRAIN);
    assign sum_o       = (state_q == DRAIN) ? acc_q : '0;
    assign busy_o      = (state_q != IDLE);
    assign count_o     = count_q;

endmodule

// File: tb/tb_snax_alu_reducer.sv
// Directed bench for snax_alu_reducer at DataWidth=8 (16-bit results); expectations are hand-computed.
module tb_snax_alu_reducer;

    localparam int DW = 8;
    localparam int LW = 16;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            start_i = 1'b0;
    logic [LW-1:0]   len_i = '0;
    logic            issue_i = 1'b0;
    logic            acc_ready_o;
    logic [2*DW-1:0] c_i = '0;
    logic            c_valid_i = 1'b0;
    logic            c_ready_o;
    logic [2*DW-1:0] sum_o;
    logic            sum_valid_o;
    logic            sum_ready_i = 1'b0;
    logic            busy_o;
    logic [LW-1:0]   count_o;

    int checks = 0;
    int errors = 0;

    snax_alu_reducer #(.DataWidth(DW), .LenWidth(LW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .len_i       (len_i),
        .issue_i     (issue_i),
        .acc_ready_o (acc_ready_o),
        .c_i         (c_i),
        .c_valid_i   (c_valid_i),
        .c_ready_o   (c_ready_o),
        .sum_o       (sum_o),
        .sum_valid_o (sum_valid_o),
        .sum_ready_i (sum_ready_i),
        .busy_o      (busy_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [LW-1:0] len);
        start_i = 1'b1;
        len_i   = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic push(input logic [2*DW-1:0] val);
        c_valid_i = 1'b1;
        c_i       = val;
        tick();
        c_valid_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      32'(busy_o),      32'd0);
        check({tag, "_acc_ready"}, 32'(acc_ready_o), 32'd0);
        check({tag, "_c_ready"},   32'(c_ready_o),   32'd0);
        check({tag, "_sum_valid"}, 32'(sum_valid_o), 32'd0);
        check({tag, "_sum"},       32'(sum_o),       32'd0);
    endtask

    logic [2*DW-1:0] sat_exp;

    initial begin
        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        check("reset_count", 32'(count_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // len=4, 1+2+3+4
        sum_ready_i = 1'b1;
        do_start(16'd4);
        check("t1_busy", 32'(busy_o), 32'd1);
        check("t1_c_ready", 32'(c_ready_o), 32'd1);
        check("t1_acc_ready", 32'(acc_ready_o), 32'd1);
        check("t1_count0", 32'(count_o), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t1_sum_valid_pre%0d", i), 32'(sum_valid_o), 32'd0);
            push(16'(i));
        end
        check("t1_sum_valid", 32'(sum_valid_o), 32'd1);
        check("t1_sum", 32'(sum_o), 32'd10);
        check("t1_count", 32'(count_o), 32'd4);
        tick();
        check("t1_idle_busy", 32'(busy_o), 32'd0);
        check("t1_idle_sum", 32'(sum_o), 32'd0);
        check("t1_idle_count", 32'(count_o), 32'd4);

        // len=3, five issue requests: only three granted
        do_start(16'd3);
        issue_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("t2_acc_ready_%0d", i), 32'(acc_ready_o), (i <= 3) ? 32'd1 : 32'd0);
            tick();
        end
        issue_i = 1'b0;
        check("t2_acc_ready_after", 32'(acc_ready_o), 32'd0);
        push(16'd5);
        push(16'd6);
        check("t2_acc_ready_still0", 32'(acc_ready_o), 32'd0);
        push(16'd7);
        check("t2_sum", 32'(sum_o), 32'd18);
        tick();

        // Zero-length reduction
        do_start(16'd0);
        check("t3_sum_valid", 32'(sum_valid_o), 32'd1);
        check("t3_sum", 32'(sum_o), 32'd0);
        check("t3_c_ready", 32'(c_ready_o), 32'd0);
        check("t3_count", 32'(count_o), 32'd0);
        tick();
        check("t3_idle", 32'(busy_o), 32'd0);

        // Back-pressure in DRAIN, start pulses ignored
        sum_ready_i = 1'b0;
        do_start(16'd2);
        push(16'h0030);
        push(16'h0012);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_hold_valid_%0d", i), 32'(sum_valid_o), 32'd1);
            check($sformatf("t4_hold_sum_%0d", i), 32'(sum_o), 32'h42);
            start_i = 1'b1;
            len_i   = 16'd9;
            tick();
        end
        start_i = 1'b0;
        check("t4_still_drain", 32'(sum_valid_o), 32'd1);
        check("t4_count", 32'(count_o), 32'd2);
        sum_ready_i = 1'b1;
        tick();
        check("t4_idle", 32'(busy_o), 32'd0);
        check("t4_idle_count", 32'(count_o), 32'd2);

        // Overflow: wrap or saturate depending on build
`ifdef SNAX_ALU_REDUCER_SAT_EN
        sat_exp = 16'hFFFF;
`else
        sat_exp = 16'h0001;
`endif
        do_start(16'd2);
        push(16'hFFFF);
        push(16'h0002);
        check("t5_overflow_sum", 32'(sum_o), 32'(sat_exp));
        tick();

        // Reset mid-reduction, then a fresh reduction
        do_start(16'd4);
        c_valid_i = 1'b1;
        c_i = 16'd3;
        tick();
        c_i = 16'd4;
        tick();
        check("t6_count_mid", 32'(count_o), 32'd2);
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        check("t6_rst_count", 32'(count_o), 32'd0);
        c_valid_i = 1'b0;
        #1;
        rst_ni = 1'b1;
        do_start(16'd1);
        push(16'd7);
        check("t6_sum", 32'(sum_o), 32'd7);
        check("t6_sum_valid", 32'(sum_valid_o), 32'd1);
        tick();
        check("t6_idle", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
